// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single rv32 memory bus between instruction
// fetch and data load/store. One transaction at a time, data before fetch,
// byte-lane steering on stores and sign-extended byte loads.
module mem_bus_arbiter (
    input  logic        clk,
    input  logic        nRst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,

    input  logic        dm_read,
    input  logic        dm_write,
    input  logic        dm_byte,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,

    output logic        freeze,

    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    output logic        bus_ren,
    output logic        bus_wen,
    input  logic [31:0] bus_rdata,
    input  logic        bus_busy
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        FETCH
    } state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  sel_q;
    logic        ren_q;
    logic        wen_q;
    logic [1:0]  lane_q;
    logic        byte_q;

    logic        dm_req;
    logic [3:0]  dm_sel;
    logic [31:0] dm_wdata_steered;
    logic [7:0]  load_byte;

    // Instruction addresses are always word aligned; the low bits carry nothing.
    logic        unused_if_addr_bits;
    assign unused_if_addr_bits = ^if_addr[1:0];

    assign dm_req = dm_read | dm_write;

    // Byte-lane enables and replicated store data for a data request.
    always_comb begin
        dm_sel           = 4'hF;
        dm_wdata_steered = dm_wdata;
        if (dm_byte) begin
            dm_sel           = 4'b0001 << dm_addr[1:0];
            dm_wdata_steered = {4{dm_wdata[7:0]}};
        end
    end

    // Sequencer: loads the bus registers on a grant and holds them until the bus is ready.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            lane_q  <= '0;
            byte_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dm_req) begin
                        // A simultaneous read and write is treated as a store.
                        addr_q  <= {dm_addr[31:2], 2'b00};
                        wdata_q <= dm_wdata_steered;
                        sel_q   <= dm_sel;
                        ren_q   <= ~dm_write;
                        wen_q   <= dm_write;
                        lane_q  <= dm_addr[1:0];
                        byte_q  <= dm_byte;
                        state_q <= DATA;
                    end else if (if_req) begin
                        addr_q  <= {if_addr[31:2], 2'b00};
                        wdata_q <= '0;
                        sel_q   <= 4'hF;
                        ren_q   <= 1'b1;
                        wen_q   <= 1'b0;
                        state_q <= FETCH;
                    end else begin
                        ren_q <= 1'b0;
                        wen_q <= 1'b0;
                    end
                end
                DATA: begin
                    if (!bus_busy) begin
                        // A pending fetch goes straight out, skipping the idle gap.
                        if (if_req) begin
                            addr_q  <= {if_addr[31:2], 2'b00};
                            wdata_q <= '0;
                            sel_q   <= 4'hF;
                            ren_q   <= 1'b1;
                            wen_q   <= 1'b0;
                            state_q <= FETCH;
                        end else begin
                            ren_q   <= 1'b0;
                            wen_q   <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                FETCH: begin
                    if (!bus_busy) begin
                        ren_q   <= 1'b0;
                        wen_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    ren_q   <= 1'b0;
                    wen_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_sel   = sel_q;
    assign bus_ren   = ren_q;
    assign bus_wen   = wen_q;

    assign if_ack = (state_q == FETCH) && !bus_busy;
    assign dm_ack = (state_q == DATA) && !bus_busy;

    assign if_rdata  = if_ack ? bus_rdata : '0;
    assign load_byte = bus_rdata[{lane_q, 3'b000} +: 8];

    // Load return: word passthrough or sign-extended byte lane; zero otherwise.
    always_comb begin
        dm_rdata = '0;
        if (dm_ack && !wen_q) begin
            if (byte_q) begin
                dm_rdata = {{24{load_byte[7]}}, load_byte};
            end else begin
                dm_rdata = bus_rdata;
            end
        end
    end

    assign freeze = (if_req & ~if_ack) | (dm_req & ~dm_ack);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter against a transaction-level model.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        nRst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_read;
    logic        dm_write;
    logic        dm_byte;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        freeze;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic        bus_ren;
    logic        bus_wen;
    logic [31:0] bus_rdata;
    logic        bus_busy;

    int unsigned n_total = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk       (clk),
        .nRst      (nRst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .dm_read   (dm_read),
        .dm_write  (dm_write),
        .dm_byte   (dm_byte),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ack    (dm_ack),
        .freeze    (freeze),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_sel   (bus_sel),
        .bus_ren   (bus_ren),
        .bus_wen   (bus_wen),
        .bus_rdata (bus_rdata),
        .bus_busy  (bus_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: expected word-aligned address.
    function automatic logic [31:0] align(input logic [31:0] a);
        return a - (a % 4);
    endfunction

    // Reference: byte lane picked out arithmetically and sign-extended.
    function automatic logic [31:0] sext_lane(input logic [31:0] w, input int unsigned lane);
        int unsigned b;
        b = (w / (1 << (8 * lane))) % 256;
        if (b >= 128) return 32'hFFFF_FF00 | b;
        return b;
    endfunction

    // One data transaction, optionally with a fetch raised at the same time.
    // Starts and ends just after a rising edge with the DUT idle.
    task automatic run_data(input bit rd, input bit wr, input bit byt,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int unsigned nbusy,
                            input bit with_fetch, input logic [31:0] faddr,
                            input logic [31:0] frdata);
        logic [31:0] e_addr, e_wdata, e_rdata;
        logic [3:0]  e_sel;
        int unsigned lane;
        lane    = addr % 4;
        e_addr  = align(addr);
        e_sel   = byt ? 4'(1 << lane) : 4'hF;
        e_wdata = byt ? (wdata % 256) * 32'h0101_0101 : wdata;
        if (wr)       e_rdata = 32'h0;
        else if (byt) e_rdata = sext_lane(rdata, lane);
        else          e_rdata = rdata;

        dm_read  = rd;
        dm_write = wr;
        dm_byte  = byt;
        dm_addr  = addr;
        dm_wdata = wdata;
        if_req   = with_fetch;
        if_addr  = faddr;
        bus_busy = 1'b0;
        @(negedge clk);
        chk("req_freeze", freeze, 1);
        chk("req_noack", dm_ack, 0);
        tick();

        for (int i = 0; i < int'(nbusy); i++) begin
            bus_busy  = 1'b1;
            bus_rdata = $urandom;
            @(negedge clk);
            chk("wait_addr", bus_addr, e_addr);
            chk("wait_sel", bus_sel, e_sel);
            chk("wait_wdata", bus_wdata, e_wdata);
            chk("wait_ren", bus_ren, !wr);
            chk("wait_wen", bus_wen, wr);
            chk("wait_ack", dm_ack, 0);
            chk("wait_rdata", dm_rdata, 0);
            chk("wait_freeze", freeze, 1);
            tick();
        end

        bus_busy  = 1'b0;
        bus_rdata = rdata;
        @(negedge clk);
        chk("done_addr", bus_addr, e_addr);
        chk("done_sel", bus_sel, e_sel);
        chk("done_wdata", bus_wdata, e_wdata);
        chk("done_ren", bus_ren, !wr);
        chk("done_wen", bus_wen, wr);
        chk("done_ack", dm_ack, 1);
        chk("done_rdata", dm_rdata, e_rdata);
        chk("done_ifack", if_ack, 0);
        chk("done_freeze", freeze, with_fetch);
        tick();
        dm_read  = 1'b0;
        dm_write = 1'b0;

        if (with_fetch) begin
            bus_rdata = frdata;
            @(negedge clk);
            chk("chain_addr", bus_addr, align(faddr));
            chk("chain_ren", bus_ren, 1);
            chk("chain_wen", bus_wen, 0);
            chk("chain_sel", bus_sel, 4'hF);
            chk("chain_ack", if_ack, 1);
            chk("chain_rdata", if_rdata, frdata);
            chk("chain_freeze", freeze, 0);
            tick();
            if_req = 1'b0;
        end

        @(negedge clk);
        chk("gap_ren", bus_ren, 0);
        chk("gap_wen", bus_wen, 0);
        tick();
    endtask

    task automatic run_fetch(input logic [31:0] faddr, input logic [31:0] frdata,
                             input int unsigned nbusy);
        if_req   = 1'b1;
        if_addr  = faddr;
        bus_busy = 1'b0;
        @(negedge clk);
        chk("f_req_freeze", freeze, 1);
        tick();
        for (int i = 0; i < int'(nbusy); i++) begin
            bus_busy  = 1'b1;
            bus_rdata = $urandom;
            @(negedge clk);
            chk("f_wait_addr", bus_addr, align(faddr));
            chk("f_wait_ren", bus_ren, 1);
            chk("f_wait_ack", if_ack, 0);
            chk("f_wait_rdata", if_rdata, 0);
            chk("f_wait_freeze", freeze, 1);
            tick();
        end
        bus_busy  = 1'b0;
        bus_rdata = frdata;
        @(negedge clk);
        chk("f_addr", bus_addr, align(faddr));
        chk("f_ren", bus_ren, 1);
        chk("f_wen", bus_wen, 0);
        chk("f_sel", bus_sel, 4'hF);
        chk("f_wdata", bus_wdata, 0);
        chk("f_ack", if_ack, 1);
        chk("f_rdata", if_rdata, frdata);
        chk("f_freeze", freeze, 0);
        tick();
        if_req = 1'b0;
        @(negedge clk);
        chk("f_gap_ren", bus_ren, 0);
        chk("f_gap_ack", if_ack, 0);
        tick();
    endtask

    initial begin
        int unsigned kind;
        nRst      = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_read   = 1'b0;
        dm_write  = 1'b0;
        dm_byte   = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        bus_rdata = '0;
        bus_busy  = 1'b0;
        #2;
        chk("rst_addr", bus_addr, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_sel", bus_sel, 0);
        chk("rst_ren", bus_ren, 0);
        chk("rst_wen", bus_wen, 0);
        chk("rst_acks", {if_ack, dm_ack}, 0);
        chk("rst_rdata", if_rdata | dm_rdata, 0);
        tick();
        nRst = 1'b1;
        tick();

        // Reset in the middle of a waited load: everything drops at once.
        dm_read = 1'b1;
        dm_addr = 32'h0000_0010;
        tick();
        bus_busy = 1'b1;
        @(negedge clk);
        chk("pre_rst_ren", bus_ren, 1);
        #1;
        nRst = 1'b0;
        #1;
        chk("mid_rst_ren", bus_ren, 0);
        chk("mid_rst_wen", bus_wen, 0);
        chk("mid_rst_sel", bus_sel, 0);
        bus_busy = 1'b0;
        #1;
        chk("mid_rst_dmack", dm_ack, 0);
        chk("mid_rst_ifack", if_ack, 0);
        dm_read = 1'b0;
        tick();
        nRst = 1'b1;
        tick();
        @(negedge clk);
        chk("post_rst_ren", bus_ren, 0);
        chk("post_rst_wen", bus_wen, 0);
        tick();

        // Fetch only, no wait states.
        run_fetch(32'h0000_0104, 32'h0050_0093, 0);
        // lb 0x203 together with a fetch of 0x108.
        run_data(1, 0, 1, 32'h0000_0203, 32'h0, 32'h80FF_FFFF, 0, 1, 32'h0000_0108, 32'h0000_0013);
        // sb 0x302 with three busy cycles.
        run_data(0, 1, 1, 32'h0000_0302, 32'h0000_00AB, 32'h0, 3, 0, 32'h0, 32'h0);
        // Read and write both high: a word store.
        run_data(1, 1, 0, 32'h0000_0040, 32'h1234_5678, 32'hCAFE_F00D, 0, 0, 32'h0, 32'h0);
        // Word load from a misaligned address.
        run_data(1, 0, 0, 32'h0000_0047, 32'h0, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h0);
        // Positive byte in lane 1.
        run_data(1, 0, 1, 32'h0000_0501, 32'h0, 32'h1122_7F44, 1, 0, 32'h0, 32'h0);

        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 5);
            if (kind == 0) begin
                run_fetch($urandom, $urandom, $urandom_range(0, 3));
            end else begin
                run_data(kind == 1 || kind == 2 || kind == 5,
                         kind >= 3,
                         kind == 2 || kind == 4,
                         $urandom, $urandom, $urandom,
                         $urandom_range(0, 3),
                         1'($urandom_range(0, 1)),
                         $urandom, $urandom);
            end
        end

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
